// File: rtl/hilo_md_unit_if.sv
// Request/response bundle between the E stage and the HI/LO multiply/divide unit.
interface hilo_md_unit_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 3;

    logic              start;
    logic [OP_W-1:0]   mdOp;
    logic              cancel;
    logic [DATA_W-1:0] rsData;
    logic [DATA_W-1:0] rtData;
    logic [DATA_W-1:0] HI;
    logic [DATA_W-1:0] LO;
    logic              busy;

    modport master (output start, mdOp, cancel, rsData, rtData, input HI, LO, busy);
    modport slave  (input start, mdOp, cancel, rsData, rtData, output HI, LO, busy);
endinterface

// File: rtl/hilo_md_unit.sv
// Fixed-latency multiply/divide unit owning the HI/LO register pair.
// Results are computed at acceptance and held until the countdown expires.
module hilo_md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic           clk,
    input  logic           reset,
    hilo_md_unit_if.slave  md
);
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned PROD_W     = 2 * DATA_W;
    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} stateT;

    stateT             state, nextState;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] hiReg, loReg, resHi, resLo;
    logic              resValid, busyReg;

    logic              accept_c, isMulDiv_c, isMult_c;
    logic              loadRes_c, writeBack_c, wrHi_c, wrLo_c;
    logic [PROD_W-1:0] extA_c, extB_c, prod_c;
    logic [DATA_W-1:0] magA_c, magB_c, divisor_c, q_c, r_c, quot_c, rem_c;
    logic              negA_c, negB_c, divZero_c;

    assign isMult_c   = (md.mdOp == OP_MULT) || (md.mdOp == OP_MULTU);
    assign isMulDiv_c = (md.mdOp >= OP_MULT) && (md.mdOp <= OP_DIVU);
    assign accept_c   = md.start && !md.cancel && (state == IDLE)
                        && (md.mdOp >= OP_MULT) && (md.mdOp <= OP_MTLO);

    // Multiply: sign-extend for mult so one 64-bit product serves both flavours.
    always_comb begin
        extA_c = {{DATA_W{(md.mdOp == OP_MULT) & md.rsData[DATA_W-1]}}, md.rsData};
        extB_c = {{DATA_W{(md.mdOp == OP_MULT) & md.rtData[DATA_W-1]}}, md.rtData};
        prod_c = extA_c * extB_c;
    end

    // Divide on magnitudes; signs restored afterwards so 0x80000000/-1 wraps naturally.
    always_comb begin
        negA_c    = (md.mdOp == OP_DIV) && md.rsData[DATA_W-1];
        negB_c    = (md.mdOp == OP_DIV) && md.rtData[DATA_W-1];
        magA_c    = negA_c ? (~md.rsData + DATA_W'(1)) : md.rsData;
        magB_c    = negB_c ? (~md.rtData + DATA_W'(1)) : md.rtData;
        divZero_c = (md.rtData == '0);
        divisor_c = divZero_c ? DATA_W'(1) : magB_c;
        q_c       = magA_c / divisor_c;
        r_c       = magA_c % divisor_c;
        quot_c    = (negA_c ^ negB_c) ? (~q_c + DATA_W'(1)) : q_c;
        rem_c     = negA_c ? (~r_c + DATA_W'(1)) : r_c;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept_c && isMulDiv_c) nextState = RUN;
            RUN:     if (cnt == CNT_W'(1)) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        loadRes_c   = 1'b0;
        writeBack_c = 1'b0;
        wrHi_c      = 1'b0;
        wrLo_c      = 1'b0;
        case (state)
            IDLE: begin
                loadRes_c = accept_c && isMulDiv_c;
                wrHi_c    = accept_c && (md.mdOp == OP_MTHI);
                wrLo_c    = accept_c && (md.mdOp == OP_MTLO);
            end
            RUN:     writeBack_c = (cnt == CNT_W'(1));
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            resHi    <= '0;
            resLo    <= '0;
            resValid <= 1'b0;
            hiReg    <= '0;
            loReg    <= '0;
            busyReg  <= 1'b0;
        end else begin
            busyReg <= (nextState == RUN);
            if (loadRes_c) begin
                cnt      <= isMult_c ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                resValid <= isMult_c || !divZero_c;
                resHi    <= isMult_c ? prod_c[PROD_W-1:DATA_W] : rem_c;
                resLo    <= isMult_c ? prod_c[DATA_W-1:0]     : quot_c;
            end else if (state == RUN) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (writeBack_c && resValid) begin
                hiReg <= resHi;
                loReg <= resLo;
            end
            if (wrHi_c) hiReg <= md.rsData;
            if (wrLo_c) loReg <= md.rsData;
        end
    end

    assign md.HI   = hiReg;
    assign md.LO   = loReg;
    assign md.busy = busyReg;

endmodule

// File: tb/tb_hilo_md_unit.sv
// Self-checking bench for hilo_md_unit: directed plan steps plus random ops
// compared against an arithmetic model of the HI/LO pair.
module tb_hilo_md_unit;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic reset;
    int   nAsserts = 0;
    int   nFails   = 0;
    logic [31:0] expHi = '0;
    logic [31:0] expLo = '0;

    hilo_md_unit_if md();

    hilo_md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkState(input string tag, input logic expBusy);
        chk({tag, ".busy"}, {31'b0, md.busy}, {31'b0, expBusy});
        chk({tag, ".HI"}, md.HI, expHi);
        chk({tag, ".LO"}, md.LO, expLo);
    endtask

    // Reference results straight from the instruction definitions.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic wr, output logic [31:0] h, output logic [31:0] l);
        longint p, q, r;
        longint unsigned pu;
        wr = 1'b1; h = '0; l = '0;
        case (op)
            3'd1: begin
                p = longint'($signed(a)) * longint'($signed(b));
                h = p[63:32]; l = p[31:0];
            end
            3'd2: begin
                pu = longint'({32'b0, a}) * longint'({32'b0, b});
                h = pu[63:32]; l = pu[31:0];
            end
            3'd3: begin
                if (b == 0) wr = 1'b0;
                else begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    h = r[31:0]; l = q[31:0];
                end
            end
            3'd4: begin
                if (b == 0) wr = 1'b0;
                else begin
                    h = a % b; l = a / b;
                end
            end
            default: wr = 1'b0;
        endcase
    endtask

    // Issue one op; during a mult/div, optionally inject start(mthi) then cancel.
    task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int disturbAt);
        logic wr;
        logic [31:0] h, l;
        int n;
        @(negedge clk);
        md.start = 1'b1; md.cancel = 1'b0; md.mdOp = op; md.rsData = a; md.rtData = b;
        @(posedge clk); #1;
        md.start = 1'b0; md.rsData = $urandom; md.rtData = $urandom;
        if (op == 3'd5) expHi = a;
        if (op == 3'd6) expLo = a;
        if (op >= 3'd1 && op <= 3'd4) begin
            model(op, a, b, wr, h, l);
            n = (op <= 3'd2) ? MULT_N : DIV_N;
            checkState({tag, ".e0"}, 1'b1);
            for (int k = 1; k <= n; k++) begin
                @(negedge clk);
                md.start  = (k == disturbAt);
                md.cancel = (k == disturbAt + 1);
                md.mdOp   = 3'd5;
                md.rsData = 32'hDEADBEEF;
                @(posedge clk); #1;
                if (k == n && wr) begin
                    expHi = h; expLo = l;
                end
                checkState($sformatf("%s.c%0d", tag, k), k < n);
            end
            md.start = 1'b0; md.cancel = 1'b0;
        end else begin
            checkState({tag, ".e0"}, 1'b0);
        end
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int          sel, n;

        reset = 1'b0;
        md.start = 1'b0; md.cancel = 1'b0; md.mdOp = '0; md.rsData = '0; md.rtData = '0;
        #1 checkState("reset", 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1 checkState("postReset", 1'b0);

        runOp("mult", 3'd1, 32'hFFFFFFFD, 32'd5, 0);
        runOp("multu", 3'd2, 32'hFFFFFFFF, 32'd2, 0);
        runOp("div", 3'd3, 32'hFFFFFFF9, 32'd2, 0);
        chk("divNeg7.LO", md.LO, 32'hFFFFFFFD);
        chk("divNeg7.HI", md.HI, 32'hFFFFFFFF);
        runOp("divOvf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 0);
        chk("divOvf.LO", md.LO, 32'h80000000);
        chk("divOvf.HI", md.HI, 32'h00000000);

        runOp("mthi", 3'd5, 32'h11111111, 32'd0, 0);
        runOp("mtlo", 3'd6, 32'h22222222, 32'd0, 0);
        runOp("divu0", 3'd4, 32'd7, 32'd0, 0);
        chk("divu0.HI", md.HI, 32'h11111111);
        chk("divu0.LO", md.LO, 32'h22222222);

        runOp("multDisturb", 3'd1, 32'h00012345, 32'hFFFF0003, 2);

        // Idle start with cancel, and start with no-op codes, must do nothing.
        @(negedge clk);
        md.start = 1'b1; md.cancel = 1'b1; md.mdOp = 3'd1; md.rsData = 32'd3; md.rtData = 32'd3;
        @(posedge clk); #1 checkState("idleCancelMult", 1'b0);
        @(negedge clk); md.mdOp = 3'd5;
        @(posedge clk); #1 checkState("idleCancelMthi", 1'b0);
        @(negedge clk); md.cancel = 1'b0; md.mdOp = 3'd0;
        @(posedge clk); #1 checkState("nop0", 1'b0);
        @(negedge clk); md.mdOp = 3'd7;
        @(posedge clk); #1 checkState("nop7", 1'b0);
        @(negedge clk); md.start = 1'b0;

        // Random ops, back-to-back or with short gaps, some disturbed mid-flight.
        for (int i = 0; i < 30; i++) begin
            op  = 3'($urandom_range(1, 6));
            a   = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
            sel = $urandom_range(0, 7);
            b   = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFFFFFF :
                  (sel == 2) ? 32'($urandom_range(1, 100)) : 32'($urandom);
            n   = (op <= 3'd2) ? MULT_N : DIV_N;
            runOp($sformatf("rnd%0d", i), op, a, b, $urandom_range(0, n));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        // Async reset in the middle of a divide, away from any clock edge.
        runOp("preHi", 3'd5, 32'hA5A5A5A5, 32'd0, 0);
        runOp("preLo", 3'd6, 32'h5A5A5A5A, 32'd0, 0);
        @(negedge clk);
        md.start = 1'b1; md.mdOp = 3'd3; md.rsData = 32'd1000; md.rtData = 32'd7;
        @(posedge clk); #1 md.start = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        expHi = '0; expLo = '0;
        #1 checkState("asyncReset", 1'b0);
        @(negedge clk) reset = 1'b1;
        for (int k = 0; k < DIV_N + 2; k++) begin
            @(posedge clk); #1 checkState($sformatf("noLateWb%0d", k), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end
endmodule
